reorder_buffer: RTL and testbench

//  In-order retirement queue downstream of the RS/ALU and LSB result buses. Allocates one entry per

---
 rtl/reorder_buffer_pkg.sv | 23 ++
 rtl/reorder_buffer_if.sv | 60 ++++++
 rtl/reorder_buffer.sv | 125 ++++++++++++
 tb/tb_reorder_buffer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared sizing constants and entry types for the reorder buffer.
// Entry indices are ROB_BIT wide and wrap modulo ROB_SIZE.
package reorder_buffer_pkg;

   localparam int ROB_SIZE = 8;
   localparam int ROB_BIT  = 3;

   typedef enum logic [1:0] {
      KIND_REG    = 2'd0,
      KIND_BRANCH = 2'd1,
      KIND_STORE  = 2'd2
   } rob_kind_e;

   typedef struct packed {
      logic        busy;
      logic        ready;
      rob_kind_e   kind;
      logic [4:0]  rd;
      logic [31:0] pred_pc;
      logic [31:0] value;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of signals between the reorder buffer and the decoder, RS/ALU, LSB and regfile.
// Issue handshake: an issue is taken on a clock edge where issue_valid=1 and is_full=0;
// is_full acts as the inverted ready, and an issue seen while full is dropped.
interface reorder_buffer_if;
   import reorder_buffer_pkg::*;

   logic               issue_valid;
   logic [1:0]         issue_kind;
   logic [4:0]         issue_rd;
   logic [31:0]        issue_pred_pc;
   logic [ROB_BIT-1:0] tail_entry;
   logic               is_full;

   logic               rs_ready;
   logic [ROB_BIT-1:0] rs_rob_entry;
   logic [31:0]        rs_value;
   logic               lsb_ready;
   logic [ROB_BIT-1:0] lsb_rob_entry;
   logic [31:0]        lsb_value;

   logic [ROB_BIT-1:0] q1_entry;
   logic [ROB_BIT-1:0] q2_entry;
   logic               q1_ready;
   logic               q2_ready;
   logic [31:0]        q1_value;
   logic [31:0]        q2_value;

   logic               commit_valid;
   logic [4:0]         commit_rd;
   logic [31:0]        commit_value;
   logic [ROB_BIT-1:0] commit_entry;
   logic               store_commit;
   logic               rob_clear_up;
   logic [31:0]        clear_pc;

   // Debug view of the queue pointers for checkers.
   logic [ROB_BIT-1:0] dbg_head;
   logic [ROB_BIT:0]   dbg_count;

   modport master (
      output issue_valid, issue_kind, issue_rd, issue_pred_pc,
      output rs_ready, rs_rob_entry, rs_value,
      output lsb_ready, lsb_rob_entry, lsb_value,
      output q1_entry, q2_entry,
      input  tail_entry, is_full, q1_ready, q2_ready, q1_value, q2_value,
      input  commit_valid, commit_rd, commit_value, commit_entry,
      input  store_commit, rob_clear_up, clear_pc, dbg_head, dbg_count
   );

   modport slave (
      input  issue_valid, issue_kind, issue_rd, issue_pred_pc,
      input  rs_ready, rs_rob_entry, rs_value,
      input  lsb_ready, lsb_rob_entry, lsb_value,
      input  q1_entry, q2_entry,
      output tail_entry, is_full, q1_ready, q2_ready, q1_value, q2_value,
      output commit_valid, commit_rd, commit_value, commit_entry,
      output store_commit, rob_clear_up, clear_pc, dbg_head, dbg_count
   );

endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates at tail, captures ALU/LSB results, answers operand
// queries with same-cycle bypass, and retires the head to regfile/LSB or flushes on mispredict.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic            clk_in,
   input  logic            rst_in,
   input  logic            rdy_in,
   reorder_buffer_if.slave rob
);

   rob_entry_t         ent [ROB_SIZE];
   rob_entry_t         head_ent;
   logic [ROB_BIT-1:0] head;
   logic [ROB_BIT-1:0] tail;
   logic [ROB_BIT:0]   count;
   logic               full;
   logic               issue_acc;
   logic               retire;

   logic               commit_valid_q;
   logic               store_commit_q;
   logic               clear_q;
   logic [4:0]         commit_rd_q;
   logic [31:0]        commit_value_q;
   logic [ROB_BIT-1:0] commit_entry_q;
   logic [31:0]        clear_pc_q;

   assign head_ent  = ent[head];
   assign full      = (count == (ROB_BIT+1)'(ROB_SIZE));
   assign issue_acc = rob.issue_valid && !full;
   assign retire    = head_ent.busy && head_ent.ready;

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < ROB_SIZE; i++) ent[i] <= '0;
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         commit_valid_q <= 1'b0;
         store_commit_q <= 1'b0;
         clear_q        <= 1'b0;
         commit_rd_q    <= '0;
         commit_value_q <= '0;
         commit_entry_q <= '0;
         clear_pc_q     <= '0;
      end else if (rdy_in) begin
         commit_valid_q <= 1'b0;
         store_commit_q <= 1'b0;
         clear_q        <= 1'b0;
         if (clear_q) begin
            // Flush edge: everything issued, written or retiring this cycle is dropped.
            for (int i = 0; i < ROB_SIZE; i++) begin
               ent[i].busy  <= 1'b0;
               ent[i].ready <= 1'b0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            // The later lsb assignment overrides rs when both name the same entry.
            if (rob.rs_ready && ent[rob.rs_rob_entry].busy) begin
               ent[rob.rs_rob_entry].value <= rob.rs_value;
               ent[rob.rs_rob_entry].ready <= 1'b1;
            end
            if (rob.lsb_ready && ent[rob.lsb_rob_entry].busy) begin
               ent[rob.lsb_rob_entry].value <= rob.lsb_value;
               ent[rob.lsb_rob_entry].ready <= 1'b1;
            end
            if (retire) begin
               ent[head].busy  <= 1'b0;
               ent[head].ready <= 1'b0;
               head            <= head + ROB_BIT'(1);
               commit_entry_q  <= head;
               case (head_ent.kind)
                  KIND_REG: begin
                     commit_valid_q <= 1'b1;
                     commit_rd_q    <= head_ent.rd;
                     commit_value_q <= head_ent.value;
                  end
                  KIND_STORE: store_commit_q <= 1'b1;
                  KIND_BRANCH: begin
                     if (head_ent.value != head_ent.pred_pc) begin
                        clear_q    <= 1'b1;
                        clear_pc_q <= head_ent.value;
                     end
                  end
                  default: ;
               endcase
            end
            if (issue_acc) begin
               ent[tail] <= '{busy: 1'b1, ready: 1'b0, kind: rob_kind_e'(rob.issue_kind),
                              rd: rob.issue_rd, pred_pc: rob.issue_pred_pc, value: 32'h0};
               tail      <= tail + ROB_BIT'(1);
            end
            count <= count + {{ROB_BIT{1'b0}}, issue_acc} - {{ROB_BIT{1'b0}}, retire};
         end
      end
   end

   // Pulses are held through a stall and only shown while the pipeline is running.
   assign rob.commit_valid = commit_valid_q && rdy_in;
   assign rob.store_commit = store_commit_q && rdy_in;
   assign rob.rob_clear_up = clear_q && rdy_in;
   assign rob.commit_rd    = commit_rd_q;
   assign rob.commit_value = commit_value_q;
   assign rob.commit_entry = commit_entry_q;
   assign rob.clear_pc     = clear_pc_q;
   assign rob.tail_entry   = tail;
   assign rob.is_full      = full;
   assign rob.dbg_head     = head;
   assign rob.dbg_count    = count;

   logic q1_lsb, q1_rs, q2_lsb, q2_rs;
   assign q1_lsb = rob.lsb_ready && (rob.lsb_rob_entry == rob.q1_entry);
   assign q1_rs  = rob.rs_ready  && (rob.rs_rob_entry  == rob.q1_entry);
   assign q2_lsb = rob.lsb_ready && (rob.lsb_rob_entry == rob.q2_entry);
   assign q2_rs  = rob.rs_ready  && (rob.rs_rob_entry  == rob.q2_entry);

   assign rob.q1_ready = q1_lsb || q1_rs || ent[rob.q1_entry].ready;
   assign rob.q1_value = q1_lsb ? rob.lsb_value : q1_rs ? rob.rs_value : ent[rob.q1_entry].value;
   assign rob.q2_ready = q2_lsb || q2_rs || ent[rob.q2_entry].ready;
   assign rob.q2_value = q2_lsb ? rob.lsb_value : q2_rs ? rob.rs_value : ent[rob.q2_entry].value;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic, all checked against
// a program-order queue model of the buffer.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic rdy_in = 1'b1;

  reorder_buffer_if rob_bus ();

  reorder_buffer dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .rob    (rob_bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          slot;
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] pred;
    logic        rdy;
    logic [31:0] val;
  } m_ent_t;

  m_ent_t      mq[$];        // live instructions, oldest first
  int          m_head = 0;
  logic        m_cv = 0, m_sc = 0, m_clr = 0;
  logic [2:0]  m_entry = '0;
  logic [31:0] m_cpc = '0;
  logic [36:0] exp_q[$];     // expected {commit_rd, commit_value} in retirement order

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    mq.delete();
    m_head = 0;
    m_cv = 0; m_sc = 0; m_clr = 0;
  endtask

  task automatic model_query(input logic [2:0] q, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = '0;
    foreach (mq[i]) if (mq[i].slot == int'(q) && mq[i].rdy) begin r = 1'b1; v = mq[i].val; end
    if (rob_bus.rs_ready && rob_bus.rs_rob_entry == q) begin r = 1'b1; v = rob_bus.rs_value; end
    if (rob_bus.lsb_ready && rob_bus.lsb_rob_entry == q) begin r = 1'b1; v = rob_bus.lsb_value; end
  endtask

  task automatic model_edge();
    int     sz;
    int     tail;
    bit     do_commit;
    m_ent_t front;
    if (m_clr) begin
      model_reset();
      return;
    end
    m_cv = 0; m_sc = 0; m_clr = 0;
    sz = mq.size();
    tail = (m_head + sz) % ROB_SIZE;
    do_commit = (sz > 0) && mq[0].rdy;
    if (do_commit) front = mq[0];
    foreach (mq[i]) begin
      if (rob_bus.rs_ready && mq[i].slot == int'(rob_bus.rs_rob_entry)) begin
        mq[i].rdy = 1'b1; mq[i].val = rob_bus.rs_value;
      end
      if (rob_bus.lsb_ready && mq[i].slot == int'(rob_bus.lsb_rob_entry)) begin
        mq[i].rdy = 1'b1; mq[i].val = rob_bus.lsb_value;
      end
    end
    if (do_commit) begin
      mq.delete(0);
      m_head = (m_head + 1) % ROB_SIZE;
      m_entry = 3'(front.slot);
      case (front.kind)
        2'd0: begin m_cv = 1; exp_q.push_back({front.rd, front.val}); end
        2'd2: m_sc = 1;
        2'd1: if (front.val != front.pred) begin m_clr = 1; m_cpc = front.val; end
        default: ;
      endcase
    end
    if (rob_bus.issue_valid && sz < ROB_SIZE)
      mq.push_back('{slot: tail, kind: rob_bus.issue_kind, rd: rob_bus.issue_rd,
                     pred: rob_bus.issue_pred_pc, rdy: 1'b0, val: 32'h0});
  endtask

  task automatic check_state();
    int sz;
    logic [36:0] w;
    sz = mq.size();
    check("tail_entry", rob_bus.tail_entry, (m_head + sz) % ROB_SIZE);
    check("is_full", rob_bus.is_full, sz == ROB_SIZE);
    check("count", rob_bus.dbg_count, sz);
    check("head", rob_bus.dbg_head, m_head);
    check("commit_valid", rob_bus.commit_valid, m_cv && rdy_in);
    check("store_commit", rob_bus.store_commit, m_sc && rdy_in);
    check("rob_clear_up", rob_bus.rob_clear_up, m_clr && rdy_in);
    if (m_cv && rdy_in) begin
      if (exp_q.size() == 0) check("exp_q_underflow", 1, 0);
      else begin
        w = exp_q.pop_front();
        check("commit_rd_value", {rob_bus.commit_rd, rob_bus.commit_value}, w);
      end
      check("commit_entry", rob_bus.commit_entry, m_entry);
    end
    if (m_sc && rdy_in) check("store_entry", rob_bus.commit_entry, m_entry);
    if (m_clr && rdy_in) check("clear_pc", rob_bus.clear_pc, m_cpc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    rdy_in = 1'b1;
    rob_bus.issue_valid = 1'b0;
    rob_bus.issue_kind = 2'd0;
    rob_bus.issue_rd = '0;
    rob_bus.issue_pred_pc = '0;
    rob_bus.rs_ready = 1'b0;
    rob_bus.rs_rob_entry = '0;
    rob_bus.rs_value = '0;
    rob_bus.lsb_ready = 1'b0;
    rob_bus.lsb_rob_entry = '0;
    rob_bus.lsb_value = '0;
    rob_bus.q1_entry = '0;
    rob_bus.q2_entry = '0;
  endtask

  task automatic set_issue(input logic [1:0] k, input logic [4:0] rd, input logic [31:0] pc);
    rob_bus.issue_valid = 1'b1;
    rob_bus.issue_kind = k;
    rob_bus.issue_rd = rd;
    rob_bus.issue_pred_pc = pc;
  endtask

  task automatic set_rs(input logic [2:0] e, input logic [31:0] v);
    rob_bus.rs_ready = 1'b1; rob_bus.rs_rob_entry = e; rob_bus.rs_value = v;
  endtask

  task automatic set_lsb(input logic [2:0] e, input logic [31:0] v);
    rob_bus.lsb_ready = 1'b1; rob_bus.lsb_rob_entry = e; rob_bus.lsb_value = v;
  endtask

  // One cycle: check queries combinationally, clock, update model, check state.
  task automatic step();
    logic        r;
    logic [31:0] v;
    #1;
    model_query(rob_bus.q1_entry, r, v);
    check("q1_ready", rob_bus.q1_ready, r);
    if (r) check("q1_value", rob_bus.q1_value, v);
    model_query(rob_bus.q2_entry, r, v);
    check("q2_ready", rob_bus.q2_ready, r);
    if (r) check("q2_value", rob_bus.q2_value, v);
    @(posedge clk_in);
    if (rdy_in) model_edge();
    #1;
    check_state();
    idle_inputs();
    @(negedge clk_in);
  endtask

  // Asynchronous reset pulse inside the low clock phase, checked before any edge.
  task automatic do_reset();
    #2;
    rst_in = 1'b0;
    #1;
    check("rst_tail", rob_bus.tail_entry, 0);
    check("rst_full", rob_bus.is_full, 0);
    check("rst_count", rob_bus.dbg_count, 0);
    check("rst_commit_valid", rob_bus.commit_valid, 0);
    check("rst_store_commit", rob_bus.store_commit, 0);
    check("rst_clear_up", rob_bus.rob_clear_up, 0);
    model_reset();
    #1;
    rst_in = 1'b1;
    @(negedge clk_in);
  endtask

  function automatic logic [31:0] pick_val();
    return ($urandom_range(0, 3) == 0) ? 32'h100 : $urandom;
  endfunction

  function automatic logic [2:0] pick_slot();
    if (mq.size() > 0 && $urandom_range(0, 3) != 0)
      return 3'(mq[$urandom_range(0, mq.size() - 1)].slot);
    return 3'($urandom_range(0, ROB_SIZE - 1));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst_in = 1'b0;
    #3;
    check("init_tail", rob_bus.tail_entry, 0);
    check("init_commit_valid", rob_bus.commit_valid, 0);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Reset with three live entries and a commit pulse showing.
    for (int i = 0; i < 3; i++) begin set_issue(2'd0, 5'(i + 1), 32'h0); step(); end
    set_rs(3'd0, 32'h1234); step();
    step();
    check("t1_pre_pulse", rob_bus.commit_valid, 1);
    do_reset();

    // Single REG instruction end to end.
    set_issue(2'd0, 5'd5, 32'h0); step();
    set_rs(3'd0, 32'h2A); step();
    check("t2_no_early_commit", rob_bus.commit_valid, 0);
    step();
    check("t2_commit_valid", rob_bus.commit_valid, 1);
    check("t2_commit_rd", rob_bus.commit_rd, 5);
    check("t2_commit_value", rob_bus.commit_value, 32'h2A);
    check("t2_commit_entry", rob_bus.commit_entry, 0);
    check("t2_count", rob_bus.dbg_count, 0);
    do_reset();

    // Fill, overfill, then commit with an issue against a full buffer.
    for (int i = 0; i < 8; i++) begin set_issue(2'd0, 5'(i), 32'h0); step(); end
    check("t3_full", rob_bus.is_full, 1);
    set_issue(2'd0, 5'd9, 32'h0); step();
    check("t3_ninth_count", rob_bus.dbg_count, 8);
    check("t3_ninth_tail", rob_bus.tail_entry, 0);
    set_rs(3'd0, 32'h55); step();
    set_issue(2'd0, 5'd10, 32'h0); step();
    check("t3_full_commit_count", rob_bus.dbg_count, 7);
    check("t3_full_commit_tail", rob_bus.tail_entry, 0);
    set_issue(2'd0, 5'd11, 32'h0); step();
    check("t3_refill_count", rob_bus.dbg_count, 8);
    check("t3_refill_tail", rob_bus.tail_entry, 1);
    do_reset();

    // Out-of-order writeback retires in order on consecutive cycles.
    set_issue(2'd0, 5'd1, 32'h0); step();
    set_issue(2'd0, 5'd2, 32'h0); step();
    set_rs(3'd1, 32'hB1); step();
    step();
    check("t4_blocked", rob_bus.commit_valid, 0);
    set_lsb(3'd0, 32'hA0); step();
    step();
    check("t4_first_entry", rob_bus.commit_entry, 0);
    check("t4_first_value", rob_bus.commit_value, 32'hA0);
    step();
    check("t4_second_entry", rob_bus.commit_entry, 1);
    check("t4_second_valid", rob_bus.commit_valid, 1);
    do_reset();

    // Mispredicted branch with younger entries flushes everything.
    set_issue(2'd1, 5'd0, 32'h100); step();
    set_issue(2'd0, 5'd3, 32'h0); step();
    set_issue(2'd2, 5'd0, 32'h0); step();
    set_rs(3'd0, 32'h200); step();
    step();
    check("t5_clear_up", rob_bus.rob_clear_up, 1);
    check("t5_clear_pc", rob_bus.clear_pc, 32'h200);
    set_issue(2'd0, 5'd4, 32'h0); set_rs(3'd1, 32'h9); step();
    check("t5_flush_count", rob_bus.dbg_count, 0);
    check("t5_flush_head", rob_bus.dbg_head, 0);
    check("t5_flush_tail", rob_bus.tail_entry, 0);
    do_reset();

    // Query bypass with both buses on the same entry.
    for (int i = 0; i < 3; i++) begin set_issue(2'd0, 5'(i), 32'h0); step(); end
    rob_bus.q1_entry = 3'd2;
    rob_bus.q2_entry = 3'd1;
    set_lsb(3'd2, 32'h77);
    set_rs(3'd2, 32'h11);
    #1;
    check("t6_q1_ready", rob_bus.q1_ready, 1);
    check("t6_q1_value", rob_bus.q1_value, 32'h77);
    check("t6_q2_ready", rob_bus.q2_ready, 0);
    step();
    do_reset();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 6)
        set_issue(2'($urandom_range(0, 2)), 5'($urandom_range(0, 31)), 32'h100);
      if ($urandom_range(0, 9) < 5) set_rs(pick_slot(), pick_val());
      if ($urandom_range(0, 9) < 3) set_lsb(pick_slot(), pick_val());
      rob_bus.q1_entry = 3'($urandom_range(0, ROB_SIZE - 1));
      rob_bus.q2_entry = pick_slot();
      if (!(m_cv || m_sc || m_clr) && $urandom_range(0, 15) == 0) rdy_in = 1'b0;
      step();
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
